// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table stimulus checker.
package tt_pkg;

    localparam int unsigned TT_NVEC  = 8;
    localparam int unsigned TT_IDX_W = 3;
    localparam int unsigned TT_ERR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } tt_state_e;

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable settle counter with a terminal-count flag at SETTLE-1.
module tt_settle_cnt #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/tt_stim_checker.sv
// Sweeps {x,y,z} through all 8 vectors and checks dut_out against EXP_TT.
// Optional first-mismatch capture is built when TT_FIRST_FAIL_EN is defined.
module tt_stim_checker
    import tt_pkg::*;
#(
    parameter logic [7:0]  EXP_TT = 8'h96,
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dut_out,
    output logic                x,
    output logic                y,
    output logic                z,
    output logic [TT_IDX_W-1:0] vec_idx,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [TT_ERR_W-1:0] err_cnt,
    output logic                first_fail_vld,
    output logic [TT_IDX_W-1:0] first_fail_idx
);

    localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_NVEC - 1);

    tt_state_e             r_state, w_state_nxt;
    logic [TT_IDX_W-1:0]   r_vec_idx, w_vec_nxt;
    logic [TT_ERR_W-1:0]   r_err_cnt, w_err_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_pass, w_pass_nxt;
    logic                  w_start_acc;
    logic                  w_mismatch;
    logic                  w_cnt_load;
    logic                  w_cnt_en;
    logic                  w_tc;
    logic [3:0]            w_cnt;

    tt_settle_cnt #(
        .SETTLE (SETTLE),
        .CNT_W  (4)
    ) u_settle_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (4'd0),
        .i_en       (w_cnt_en),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch  = (dut_out != EXP_TT[r_vec_idx]);

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vec_idx <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec_idx <= w_vec_nxt;
            r_err_cnt <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: if (start) w_state_nxt = DRIVE;
            DRIVE:      if (w_tc) w_state_nxt = SAMPLE;
            SAMPLE:     w_state_nxt = (r_vec_idx == LAST_IDX) ? DONE : DRIVE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_vec_nxt  = r_vec_idx;
        w_err_nxt  = r_err_cnt;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        if (w_start_acc) begin
            w_vec_nxt  = '0;
            w_err_nxt  = '0;
            w_cnt_load = 1'b1;
        end else if (r_state == DRIVE) begin
            w_cnt_en = 1'b1;
        end else if (r_state == SAMPLE) begin
            w_cnt_load = 1'b1;
            if (w_mismatch) w_err_nxt = r_err_cnt + 1'b1;
            if (r_vec_idx != LAST_IDX) w_vec_nxt = r_vec_idx + 1'b1;
        end
        w_busy_nxt = (w_state_nxt == DRIVE) || (w_state_nxt == SAMPLE);
        w_done_nxt = (w_state_nxt == DONE);
        w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
    end

`ifdef TT_FIRST_FAIL_EN
    logic                r_ff_vld, w_ff_vld_nxt;
    logic [TT_IDX_W-1:0] r_ff_idx, w_ff_idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_vld <= 1'b0;
            r_ff_idx <= '0;
        end else begin
            r_ff_vld <= w_ff_vld_nxt;
            r_ff_idx <= w_ff_idx_nxt;
        end
    end

    // Only the first mismatch of a sweep is kept.
    always_comb begin
        w_ff_vld_nxt = r_ff_vld;
        w_ff_idx_nxt = r_ff_idx;
        if (w_start_acc) begin
            w_ff_vld_nxt = 1'b0;
            w_ff_idx_nxt = '0;
        end else if ((r_state == SAMPLE) && w_mismatch && !r_ff_vld) begin
            w_ff_vld_nxt = 1'b1;
            w_ff_idx_nxt = r_vec_idx;
        end
    end

    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;
`else
    assign first_fail_vld = 1'b0;
    assign first_fail_idx = '0;
`endif

    assign x       = r_vec_idx[2];
    assign y       = r_vec_idx[1];
    assign z       = r_vec_idx[0];
    assign vec_idx = r_vec_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule
